// File: rtl/systolic_drain.sv
// rtl/systolic_drain.sv - de-skews L skewed array lanes into aligned rows written to result SRAM
// Optional performance counters are enabled with SYSTOLIC_DRAIN_PERF_EN.
module systolic_drain #(
  parameter int L      = 8,
  parameter int ENTRYS = 1024,
  parameter int WIDTH  = 32,
  parameter int AW     = $clog2(ENTRYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [AW:0]        num_rows,
  input  logic [AW-1:0]      base_addr,
  input  logic               in_advance,
  input  logic [L*WIDTH-1:0] in_data,
  output logic               we,
  output logic [AW-1:0]      wraddr,
  output logic [L*WIDTH-1:0] wdata,
`ifdef SYSTOLIC_DRAIN_PERF_EN
  output logic [31:0]        stall_cycles,
  output logic [AW:0]        row_count,
`endif
  output logic               busy,
  output logic               done
);

  localparam int CW = AW + 1 + $clog2(L);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_beat;
  logic [AW:0]        r_num;
  logic [AW-1:0]      r_addr;
  logic               w_accept;
  logic               w_adv;
  logic [CW-1:0]      w_first;
  logic [CW-1:0]      w_end;
  logic               w_in_win;
  logic               w_last;
  logic [L*WIDTH-1:0] w_row;

  assign w_accept = start && (r_state != S_DRAIN);
  assign w_adv    = (r_state == S_DRAIN) && in_advance;
  // Row r is aligned at beat r+L-1, so valid beats are [L-1, L-1+num_rows).
  assign w_first  = CW'(L - 1);
  assign w_end    = CW'(r_num) + CW'(L - 1);
  assign w_in_win = w_adv && (r_beat >= w_first) && (r_beat < w_end);
  assign w_last   = w_in_win && (r_beat == w_end - CW'(1));

  for (genvar i = 0; i < L; i++) begin : g_lane
    localparam int D = L - 1 - i;
    if (D == 0) begin : g_pass
      assign w_row[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
    end else begin : g_chain
      logic [WIDTH-1:0] r_sk [D];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < D; k++) r_sk[k] <= '0;
        end else if (w_accept) begin
          for (int k = 0; k < D; k++) r_sk[k] <= '0;
        end else if (w_adv) begin
          r_sk[0] <= in_data[i*WIDTH +: WIDTH];
          for (int k = 1; k < D; k++) r_sk[k] <= r_sk[k-1];
        end
      end
      assign w_row[i*WIDTH +: WIDTH] = r_sk[D-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = (num_rows != '0) ? S_DRAIN : S_DONE;
      S_DRAIN:        if (w_last) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat <= '0;
      r_num  <= '0;
      r_addr <= '0;
      we     <= 1'b0;
      wraddr <= '0;
      wdata  <= '0;
    end else begin
      if (w_accept) begin
        r_beat <= '0;
        r_num  <= num_rows;
        r_addr <= base_addr;
      end else if (w_adv) begin
        r_beat <= r_beat + CW'(1);
      end
      we <= w_in_win;
      if (w_in_win) begin
        wraddr <= r_addr;
        wdata  <= w_row;
        // Explicit wrap keeps addressing modulo ENTRYS even for non-power-of-two depths.
        r_addr <= (r_addr == AW'(ENTRYS - 1)) ? '0 : r_addr + AW'(1);
      end
    end
  end

  assign busy = (r_state == S_DRAIN);
  assign done = (r_state == S_DONE);

`ifdef SYSTOLIC_DRAIN_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [AW:0] r_row_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
      r_row_count    <= '0;
    end else if (w_accept) begin
      r_stall_cycles <= '0;
      r_row_count    <= '0;
    end else if (r_state == S_DRAIN) begin
      if (!in_advance && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_in_win) r_row_count <= r_row_count + (AW+1)'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign row_count    = r_row_count;
`endif

endmodule

// File: tb/tb_systolic_drain.sv
// tb/tb_systolic_drain.sv - randomized self-checking bench for systolic_drain against a row-level model
module tb_systolic_drain;
  localparam int L  = 4;
  localparam int W  = 16;
  localparam int E  = 16;
  localparam int AW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AW:0]      num_rows;
  logic [AW-1:0]    base_addr;
  logic             in_advance;
  logic [L*W-1:0]   in_data;
  logic             we;
  logic [AW-1:0]    wraddr;
  logic [L*W-1:0]   wdata;
  logic             busy;
  logic             done;
`ifdef SYSTOLIC_DRAIN_PERF_EN
  logic [31:0]      stall_cycles;
  logic [AW:0]      row_count;
`endif

  systolic_drain #(.L(L), .ENTRYS(E), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .base_addr(base_addr),
    .in_advance(in_advance), .in_data(in_data), .we(we), .wraddr(wraddr), .wdata(wdata),
`ifdef SYSTOLIC_DRAIN_PERF_EN
    .stall_cycles(stall_cycles), .row_count(row_count),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int first_beat_cyc;

  // Model: 0 idle, 1 draining, 2 done
  int m_state, m_beat, m_n, m_base;
  logic [W-1:0]   rows [0:31][0:L-1];
  logic           exp_we, exp_busy, exp_done, chk_en;
  logic [AW-1:0]  exp_addr;
  logic [L*W-1:0] exp_data;
  int             wl_cyc [$];
  int             wl_addr [$];
  logic [L*W-1:0] wl_data [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [L*W-1:0] pack(input int r);
    logic [L*W-1:0] d;
    for (int i = 0; i < L; i++) d[i*W +: W] = rows[r][i];
    return d;
  endfunction

  always @(posedge clk) begin
    #1;
    cyc++;
    if (chk_en) begin
      chk("we", {63'd0, we}, {63'd0, exp_we});
      if (exp_we && we) begin
        chk("wraddr", {60'd0, wraddr}, {60'd0, exp_addr});
        chk("wdata", wdata, exp_data);
      end
      chk("busy", {63'd0, busy}, {63'd0, exp_busy});
      chk("done", {63'd0, done}, {63'd0, exp_done});
      if (we) begin
        wl_cyc.push_back(cyc - first_beat_cyc);
        wl_addr.push_back(int'(wraddr));
        wl_data.push_back(wdata);
      end
    end
  end

  // Presents one cycle of inputs and states what the outputs must be after the coming edge.
  task automatic step(input bit st, input int n, input int base, input bit adv);
    logic [L*W-1:0] d;
    int b, r;
    for (int i = 0; i < L; i++) d[i*W +: W] = 16'hDEAD;
    start = st; num_rows = (AW+1)'(n); base_addr = AW'(base); in_advance = adv;
    exp_we = 1'b0;
    if (m_state == 1) begin
      if (adv) begin
        b = m_beat;
        if (b == 0) first_beat_cyc = cyc;
        for (int i = 0; i < L; i++) begin
          r = b - i;
          if (r >= 0 && r < m_n) d[i*W +: W] = rows[r][i];
        end
        r = b - (L - 1);
        if (r >= 0 && r < m_n) begin
          exp_we   = 1'b1;
          exp_addr = AW'((m_base + r) % E);
          exp_data = pack(r);
          if (r == m_n - 1) m_state = 2;
        end
        m_beat++;
      end
    end else if (st) begin
      m_beat = 0; m_n = n; m_base = base;
      m_state = (n > 0) ? 1 : 2;
    end
    in_data  = d;
    exp_busy = (m_state == 1);
    exp_done = (m_state == 2);
    @(negedge clk);
  endtask

  task automatic fill(input int n, input bit pattern);
    for (int r = 0; r < n; r++)
      for (int i = 0; i < L; i++)
        rows[r][i] = pattern ? W'((r << 8) | i) : W'($urandom);
  endtask

  task automatic run_drain(input int n, input int base, input int stall_at, input int p, input bit spur);
    int guard = 0;
    int stalls = 0;
    bit adv, st;
    wl_cyc.delete(); wl_addr.delete(); wl_data.delete();
    step(1'b1, n, base, 1'($urandom % 2));
    while (m_state == 1 && guard < 300) begin
      if (stall_at >= 0 && m_beat == stall_at + 1 && stalls < 2) begin
        adv = 1'b0; stalls++;
      end else begin
        adv = ($urandom_range(0, 99) < p);
      end
      st = spur && ($urandom % 8 == 0);
      step(st, st ? $urandom_range(0, 8) : 0, $urandom % E, adv);
      guard++;
    end
    if (m_state == 1) chk("drain_timeout", 64'd1, 64'd0);
    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; num_rows = '0; base_addr = '0; in_advance = 1'b0; in_data = '0;
    chk_en = 1'b0; first_beat_cyc = 0;
    m_state = 0; m_beat = 0; m_n = 0; m_base = 0;
    exp_we = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_addr = '0; exp_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_we", {63'd0, we}, 64'd0);
    chk("rst_wraddr", {60'd0, wraddr}, 64'd0);
    chk("rst_wdata", wdata, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b1; chk_en = 1'b1;

    // Zero rows from IDLE
    wl_cyc.delete(); wl_addr.delete(); wl_data.delete();
    step(1'b1, 0, 3, 1'b1);
    chk("zero_done", {63'd0, done}, 64'd1);
    chk("zero_busy", {63'd0, busy}, 64'd0);
    repeat (3) step(1'b0, 0, 0, 1'b1);
    chk("zero_writes", wl_addr.size(), 64'd0);

    // Basic drain
    fill(3, 1'b1);
    run_drain(3, 10, -1, 100, 1'b0);
    chk("basic_nwr", wl_addr.size(), 64'd3);
    if (wl_addr.size() == 3) begin
      chk("basic_a0", wl_addr[0], 64'd10);
      chk("basic_a1", wl_addr[1], 64'd11);
      chk("basic_a2", wl_addr[2], 64'd12);
      chk("basic_c0", wl_cyc[0], 64'd4);
      chk("basic_c2", wl_cyc[2], 64'd6);
      chk("basic_row1", wl_data[1], 64'h0103_0102_0101_0100);
    end

    // Restart from DONE
    fill(1, 1'b1);
    run_drain(1, 5, -1, 100, 1'b0);
    chk("restart_nwr", wl_addr.size(), 64'd1);
    if (wl_addr.size() == 1) begin
      chk("restart_a", wl_addr[0], 64'd5);
      chk("restart_c", wl_cyc[0], 64'(L));
    end

    // Stall of two cycles after beat 2
    fill(3, 1'b1);
    run_drain(3, 10, 2, 100, 1'b0);
    chk("stall_nwr", wl_addr.size(), 64'd3);
    if (wl_addr.size() == 3) begin
      chk("stall_a0", wl_addr[0], 64'd10);
      chk("stall_c0", wl_cyc[0], 64'd6);
      chk("stall_c2", wl_cyc[2], 64'd8);
      chk("stall_row1", wl_data[1], 64'h0103_0102_0101_0100);
    end
`ifdef SYSTOLIC_DRAIN_PERF_EN
    chk("perf_stall", stall_cycles, 64'd2);
    chk("perf_rows", row_count, 64'd3);
`endif

    // Address wrap
    fill(4, 1'b0);
    run_drain(4, 14, -1, 100, 1'b0);
    chk("wrap_nwr", wl_addr.size(), 64'd4);
    if (wl_addr.size() == 4) begin
      chk("wrap_a0", wl_addr[0], 64'd14);
      chk("wrap_a1", wl_addr[1], 64'd15);
      chk("wrap_a2", wl_addr[2], 64'd0);
      chk("wrap_a3", wl_addr[3], 64'd1);
    end

    // Reset during beat 4 of an 8-row drain
    fill(8, 1'b0);
    step(1'b1, 8, 7, 1'b0);
    repeat (4) step(1'b0, 0, 0, 1'b1);
    in_advance = 1'b1;
    chk_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_we", {63'd0, we}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    m_state = 0; exp_we = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    @(negedge clk);
    rst = 1'b1; chk_en = 1'b1;
    wl_cyc.delete(); wl_addr.delete(); wl_data.delete();
    repeat (8) step(1'b0, 0, 0, 1'($urandom % 2));
    chk("post_rst_writes", wl_addr.size(), 64'd0);
    fill(2, 1'b0);
    run_drain(2, 0, -1, 100, 1'b0);
    chk("fresh_nwr", wl_addr.size(), 64'd2);
    if (wl_addr.size() == 2) begin
      chk("fresh_a0", wl_addr[0], 64'd0);
      chk("fresh_a1", wl_addr[1], 64'd1);
      chk("fresh_d0", wl_data[0], pack(0));
      chk("fresh_d1", wl_data[1], pack(1));
    end

    // Randomized drains with random stalls and ignored mid-drain starts
    for (int t = 0; t < 16; t++) begin
      int n;
      n = $urandom_range(0, 9);
      fill(n, 1'b0);
      run_drain(n, $urandom % E, -1, $urandom_range(40, 100), 1'b1);
      chk("rand_nwr", wl_addr.size(), 64'(n));
      repeat ($urandom_range(0, 2)) step(1'b0, 0, 0, 1'($urandom % 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Output-side collector for the systolic array; it is the writer counterpart to the skewed A/B read scheduler.
- The array emits L result lanes, and lane i is skewed by i advance beats, in the same way as the read-side pointers that start at -i.
- The block de-skews the lanes, assembles one aligned L-lane result row per beat, and writes it to the result SRAM write port at consecutive addresses.
- It follows the same flow-or-hold rule as the array: no state moves on cycles where in_advance is low.

Parameters:
L, 8, number of array lanes (rows of PEs)
ENTRYS, 1024, result SRAM depth in rows
WIDTH, 32, bits per lane result
AW, $clog2(ENTRYS), SRAM address width (derived)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; launches a drain of num_rows rows
num_rows  input  AW+1  rows to collect; sampled on accepted start
base_addr  input  AW  first SRAM row address; sampled on accepted start
in_advance  input  1  array advance strobe (read side's AHEAD); one beat per high cycle
in_data  input  L*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
we  output  1  SRAM write enable
wraddr  output  AW  SRAM write address
wdata  output  L*WIDTH  aligned row; lane i occupies bits [i*WIDTH +: WIDTH]
busy  output  1  high in DRAIN
done  output  1  high in DONE

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; we=0, wraddr=0, wdata=0, busy=0, done=0; beat counter and all de-skew registers cleared. This applies immediately, including mid-drain; no partial write completes after reset asserts.
- States:
  - IDLE to DRAIN on start when num_rows>0.
  - IDLE to DONE on start when num_rows==0; no writes occur.
  - DRAIN to DONE on the cycle the last row's write is issued.
  - DONE to DRAIN on start when num_rows>0.
  - DONE stays in DONE on start when num_rows==0.
  - DONE otherwise holds, so done is sticky.
  - start is ignored in DRAIN.
- Skew contract: row r of lane i is present on in_data during advance beat r+i. Beats are numbered from 0, counting in_advance-high cycles in DRAIN.
- De-skew: lane i passes through a shift chain of L-1-i registers that shifts only on advance beats. Lane L-1 has zero delay. Row r is aligned at beat b=r+L-1.
- Beat counter: width AW+1+$clog2(L); increments on each advance beat in DRAIN; cleared on an accepted start.
- Write issue: on an advance beat with b in [L-1, L-2+num_rows]:
  - the next clock edge registers we=1, wraddr=(base_addr+b-(L-1)) mod ENTRYS, and wdata=aligned row.
  - otherwise the next edge registers we=0; wraddr and wdata hold their values.
- Latency: row r's write is visible one cycle after beat r+L-1. A drain with continuous advance takes num_rows+L-1 beats.
- Stall: when in_advance is low, nothing shifts, the counter holds, and we=0 on the next cycle.
- Address wrap: base_addr+num_rows>ENTRYS wraps modulo ENTRYS, with no error.
- Data outside the skew window is ignored; lane values before beat i or after beat num_rows-1+i do not reach SRAM.
- DONE entry: the same edge that registers the last we=1 moves the state to DONE. done rises together with that last we.
- start accepted in DONE: done and busy change on the next edge, and the de-skew registers clear.

Optional Feature:
- Macro: SYSTOLIC_DRAIN_PERF_EN.
- When defined, the block adds outputs stall_cycles [31:0] and row_count [AW:0]:
  - stall_cycles counts DRAIN cycles with in_advance low and saturates at all-ones.
  - row_count counts issued writes.
  - Both clear on reset and on an accepted start, and hold in DONE.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Basic drain, L=4, WIDTH=16, num_rows=3, base_addr=10, in_advance continuously high, lane i row r driven as (r<<8)|i at beat r+i and 0xDEAD elsewhere:
  - exactly 3 writes, at addresses 10, 11, 12, on cycles 4, 5, 6 after the first beat;
  - row 1 wdata = {0x0103, 0x0102, 0x0101, 0x0100} (lane 3 to lane 0);
  - done rises with the last write; no 0xDEAD is ever written.
- Stall, same stimulus with in_advance low for 2 cycles after beat 2:
  - addresses and data identical to the basic drain, with the writes delayed by exactly 2 cycles;
  - we=0 during the stall; with PERF_EN, stall_cycles=2.
- Wrap, ENTRYS=16, base_addr=14, num_rows=4: writes go to addresses 14, 15, 0, 1 in that order.
- Zero rows, start with num_rows=0: the next cycle is DONE with done=1; we never asserts; busy stays 0.
- Reset mid-drain, rst low during beat 4 of a num_rows=8 drain:
  - we, busy and done drop to 0 immediately.
  - After release, with no start, there are no writes.
  - A fresh start with num_rows=2, base_addr=0 writes rows 0 and 1 to addresses 0 and 1, containing no stale lane data.
- Restart from DONE: after a completed drain, a start with num_rows=1, base_addr=5 gives done=0 next cycle, then one write to address 5 one cycle after beat L-1, then done=1.
